alu_seq: RTL and testbench

- Registered, parametrised successor to the 4-bit combinational button-driven ALU.
- Operand width is set by WIDTH. The operation-select register steps up and down from clk-synchronous button edges.
- All eight operations are implemented with two's-complement flags, including correct subtraction and signed compare.
- Results are registered with one-cycle latency and an in_valid/out_valid strobe. The block sits between the board switch/button inputs and the LED/seven-segment display logic.

---
 rtl/alu_seq.sv | 125 ++++++++++++
 tb/tb_alu_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered eight-operation ALU with button-stepped op select.
// Rising edges on btn_up/btn_down step op_led, which saturates at 0 and 7.
// An in_valid beat is evaluated with the op select as it was at the start
// of the cycle. The result and flags appear one cycle later with a one-cycle
// out_valid pulse.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       op_led,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             out_valid
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_NOT = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SLT = 3'd6,
    OP_EQ  = 3'd7
  } op_e;

  localparam int MSB = WIDTH - 1;

  logic             r_up_q, r_dn_q;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_carry, r_zero, r_overflow, r_out_valid;

  logic             w_up_edge, w_dn_edge;
  logic [WIDTH:0]   w_sum, w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_c, w_v;

  assign w_up_edge = btn_up   & ~r_up_q;
  assign w_dn_edge = btn_down & ~r_dn_q;

  // Both sums carry one extra bit so the carry-out falls out of the add.
  // The subtract is a + ~b + 1, so its carry-out means "no borrow".
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  // Operation decode. Only ADD and SUB produce carry and overflow.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op_e'(r_op))
      OP_ADD: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_res = w_diff[MSB:0];
        w_c   = w_diff[WIDTH];
        w_v   = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
      end
      OP_NOT: w_res = ~a;
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_EQ:  w_res = {{(WIDTH-1){1'b0}}, (a == b)};
      default: w_res = '0;
    endcase
  end

  // Button history and saturating op select. The history resets to 1 so a
  // button that is held through reset release does not count as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_up_q <= 1'b1;
      r_dn_q <= 1'b1;
      r_op   <= 3'd0;
    end else begin
      r_up_q <= btn_up;
      r_dn_q <= btn_down;
      if (w_up_edge && !w_dn_edge && r_op != 3'd7)
        r_op <= r_op + 3'd1;
      else if (w_dn_edge && !w_up_edge && r_op != 3'd0)
        r_op <= r_op - 3'd1;
    end
  end

  // Result and flag registers. They load only on in_valid and otherwise
  // hold their values. out_valid marks the cycle after a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result   <= w_res;
        r_carry    <= w_c;
        r_zero     <= (w_res == '0);
        r_overflow <= w_v;
      end
    end
  end

  assign op_led    = r_op;
  assign result    = r_result;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign overflow  = r_overflow;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random stimulus for alu_seq. Every cycle is
// compared with an integer-arithmetic reference model. The directed part
// also checks the documented corner cases against literal values.
module tb_alu_seq;
  localparam int W = 4;
  localparam longint M = 64'd1 << W;
  localparam longint HALF = M / 2;

  logic         clk = 1'b0;
  logic         rst, btn_up, btn_down, in_valid;
  logic [W-1:0] a, b;
  logic [2:0]   op_led;
  logic [W-1:0] result;
  logic         carry, zero, overflow, out_valid;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int     m_op;
  bit     m_up_q, m_dn_q;
  longint m_res;
  bit     m_c, m_z, m_v, m_ov;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .in_valid(in_valid), .a(a), .b(b), .op_led(op_led), .result(result),
    .carry(carry), .zero(zero), .overflow(overflow), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic longint sgn(input longint u);
    return (u >= HALF) ? u - M : u;
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference operation. The arithmetic is done on unbounded integers.
  // Carry and overflow come from range checks, not from bit tricks.
  task automatic ref_alu(input int op, input longint ua, input longint ub,
                         output longint r, output bit c, output bit v);
    longint s;
    c = 0;
    v = 0;
    r = 0;
    case (op)
      0: begin
        s = ua + ub;
        r = s % M;
        c = (s >= M);
        s = sgn(ua) + sgn(ub);
        v = (s >= HALF) || (s < -HALF);
      end
      1: begin
        r = (ua - ub + M) % M;
        c = (ua >= ub);
        s = sgn(ua) - sgn(ub);
        v = (s >= HALF) || (s < -HALF);
      end
      2: r = M - 1 - ua;
      3: r = ua & ub;
      4: r = ua | ub;
      5: r = ua ^ ub;
      6: r = (sgn(ua) < sgn(ub)) ? 1 : 0;
      default: r = (ua == ub) ? 1 : 0;
    endcase
  endtask

  // One clock: drive the inputs at negedge, advance the model, then check
  // every output at the following negedge.
  task automatic tick(input bit up, input bit dn, input bit iv, input bit rs,
                      input logic [W-1:0] aa, input logic [W-1:0] bb);
    bit ue, de;
    btn_up = up; btn_down = dn; in_valid = iv; rst = rs; a = aa; b = bb;
    if (rs) begin
      m_op = 0; m_up_q = 1; m_dn_q = 1;
      m_res = 0; m_c = 0; m_z = 0; m_v = 0; m_ov = 0;
    end else begin
      m_ov = iv;
      if (iv) begin
        ref_alu(m_op, longint'(aa), longint'(bb), m_res, m_c, m_v);
        m_z = (m_res == 0);
      end
      ue = up && !m_up_q;
      de = dn && !m_dn_q;
      if (ue && !de && m_op < 7) m_op++;
      else if (de && !ue && m_op > 0) m_op--;
      m_up_q = up;
      m_dn_q = dn;
    end
    @(posedge clk);
    @(negedge clk);
    chk("op_led", 64'(op_led), 64'(m_op));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("result", 64'(result), 64'(m_res));
    chk("carry", 64'(carry), 64'(m_c));
    chk("zero", 64'(zero), 64'(m_z));
    chk("overflow", 64'(overflow), 64'(m_v));
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 'x, 'x);
  endtask

  task automatic up_pulse();
    tick(1, 0, 0, 0, '0, '0);
    tick(0, 0, 0, 0, '0, '0);
  endtask

  task automatic dn_pulse();
    tick(0, 1, 0, 0, '0, '0);
    tick(0, 0, 0, 0, '0, '0);
  endtask

  task automatic op(input logic [W-1:0] aa, input logic [W-1:0] bb);
    tick(0, 0, 1, 0, aa, bb);
  endtask

  task automatic goto_op(input int n);
    for (int i = 0; i < 8; i++) dn_pulse();
    for (int i = 0; i < n; i++) up_pulse();
  endtask

  initial begin
    btn_up = 0; btn_down = 0; in_valid = 0; rst = 1; a = '0; b = '0;
    @(negedge clk);
    tick(0, 0, 0, 1, '0, '0);
    tick(0, 0, 0, 1, '0, '0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_op", 64'(op_led), 64'd0);
    idle();

    // ADD, op 0.
    op(4'b0111, 4'b0001);
    chk("add_ovf_res", 64'(result), 64'b1000);
    chk("add_ovf_v", 64'(overflow), 64'd1);
    chk("add_ovf_valid", 64'(out_valid), 64'd1);
    idle();
    chk("valid_one_cycle", 64'(out_valid), 64'd0);
    chk("hold_result", 64'(result), 64'b1000);
    op(4'b1111, 4'b0001);
    chk("add_wrap_zero", 64'(zero), 64'd1);
    chk("add_wrap_carry", 64'(carry), 64'd1);

    // SUB, op 1.
    up_pulse();
    op(4'b0011, 4'b0101);
    chk("sub_borrow_res", 64'(result), 64'b1110);
    chk("sub_borrow_c", 64'(carry), 64'd0);
    op(4'b1000, 4'b0001);
    chk("sub_ovf_res", 64'(result), 64'b0111);
    chk("sub_ovf_v", 64'(overflow), 64'd1);
    chk("sub_ovf_c", 64'(carry), 64'd1);

    // NOT, op 2.
    up_pulse();
    op(4'b0101, 4'b0000);
    chk("not_res", 64'(result), 64'b1010);

    // SLT, op 6.
    goto_op(6);
    op(4'b1000, 4'b0111);
    chk("slt_true", 64'(result), 64'd1);
    op(4'b0111, 4'b1000);
    chk("slt_false_z", 64'(zero), 64'd1);

    // EQ, op 7. The tenth press must saturate.
    up_pulse();
    op(4'b0101, 4'b0101);
    chk("eq_res", 64'(result), 64'd1);

    // Saturation in both directions.
    for (int i = 0; i < 9; i++) up_pulse();
    chk("sat_hi", 64'(op_led), 64'd7);
    goto_op(0);
    dn_pulse();
    chk("sat_lo", 64'(op_led), 64'd0);

    // Simultaneous edges.
    up_pulse(); up_pulse();
    tick(1, 1, 0, 0, '0, '0);
    chk("both_edges", 64'(op_led), 64'd2);
    idle();

    // Button held for 10 cycles.
    for (int i = 0; i < 10; i++) tick(1, 0, 0, 0, '0, '0);
    chk("held_once", 64'(op_led), 64'd3);
    idle();

    // in_valid on the same cycle as an up edge uses the old op (ADD).
    goto_op(0);
    tick(1, 0, 1, 0, 4'b0011, 4'b0001);
    chk("edge_iv_res", 64'(result), 64'b0100);
    chk("edge_iv_op", 64'(op_led), 64'd1);
    idle();

    // Reset overrides in_valid, and a button held through the reset release
    // does not count as an edge.
    tick(1, 0, 1, 1, 4'b0011, 4'b0001);
    chk("rst_iv_valid", 64'(out_valid), 64'd0);
    chk("rst_iv_res", 64'(result), 64'd0);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, '0, '0);
    chk("held_thru_rst", 64'(op_led), 64'd0);
    idle();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           $urandom_range(0, 1) == 1, ($urandom_range(0, 79) == 0),
           W'($urandom), W'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
